qeciphy_tx_controller: RTL and testbench
========================================

Name: qeciphy_tx_controller

Overview:
- Controls the TX path from disable through link training to normal data transmission, and handles faults.
- Sits between qeciphy_controller and the qeciphy_tx_* datapath modules.
- Selects what the TX datapath sends (idle, training pattern, data) and advertises local readiness to the link partner.
- Reports TX readiness, sticky fatal faults and an error code upward.

Parameters:
- MIN_TRAIN_CYCLES, 1024: minimum number of cycles the training pattern is sent before local readiness may be advertised.
- TIMEOUT_CYCLES, 1048576: maximum number of cycles spent in TRAINING plus WAIT_REMOTE before a timeout fault.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- enable_i  in  1  global enable
- rx_rdy_i  in  1  local RX path locked and ready (partner is transmitting validly)
- remote_rx_rdy_i  in  1  partner's RX-ready flag, decoded from received frames
- fifo_overflow_i  in  1  TX FIFO overflow (sticky from source)
- tx_enable_o  out  1  enable for the TX subsystem
- tx_mode_o  out  2  qeciphy_tx_mode_t: TX_IDLE / TX_TRAIN / TX_DATA
- local_rdy_flag_o  out  1  local-ready bit inserted into outgoing frames
- tx_rdy_o  out  1  TX ready for normal operation
- tx_fault_fatal_o  out  1  fatal fault (sticky)
- tx_error_code_o  out  4  qeciphy_error_t (sticky)

Behaviour:
- Clock and reset: one clock, clk_i. rst_n_i is asynchronous and active-low.
- Reset values:
  - State is RESET.
  - Counters are 0.
  - tx_enable_o=0, tx_mode_o=TX_IDLE, local_rdy_flag_o=0, tx_rdy_o=0, tx_fault_fatal_o=0, tx_error_code_o=NO_ERROR.
- State encoding and outputs:
  - States are one-hot: RESET, OFF, TRAINING, WAIT_REMOTE, READY, FAULT_FATAL.
  - All outputs are decoded from registered state or registered error code; there is no combinational path from inputs.
- Enable override: enable_i=0 forces the next state to OFF and clears both counters and the error code on the same edge. This has priority over every transition except reset.
- RESET: go to OFF next cycle.
- OFF:
  - Outputs are all zero or idle.
  - With enable_i=1, go to TRAINING next cycle.
  - Reset release with enable_i held high gives TRAINING on the 2nd clock edge.
- TRAINING:
  - tx_enable_o=1, tx_mode_o=TX_TRAIN.
  - train_cnt increments each cycle and saturates at MIN_TRAIN_CYCLES.
  - Go to WAIT_REMOTE when train_cnt==MIN_TRAIN_CYCLES and rx_rdy_i=1.
  - Minimum dwell is MIN_TRAIN_CYCLES+1 cycles.
- WAIT_REMOTE:
  - tx_mode_o=TX_TRAIN, local_rdy_flag_o=1.
  - Go to READY when remote_rx_rdy_i=1.
  - If rx_rdy_i drops, return to TRAINING. train_cnt is cleared; tmo_cnt keeps counting.
- Timeout:
  - tmo_cnt is cleared on entry to TRAINING from OFF.
  - It increments in TRAINING and WAIT_REMOTE and saturates at TIMEOUT_CYCLES.
  - When tmo_cnt==TIMEOUT_CYCLES and no forward transition fires that cycle, go to FAULT_FATAL with TX_TRAIN_TIMEOUT.
  - If a forward transition and the timeout coincide, the forward transition wins.
- READY:
  - tx_mode_o=TX_DATA, local_rdy_flag_o=1, tx_rdy_o=1.
  - fifo_overflow_i=1 goes to FAULT_FATAL with TX_FIFO_OVERFLOW.
  - Otherwise, remote_rx_rdy_i=0 or rx_rdy_i=0 goes to FAULT_FATAL with TX_LINK_LOST.
  - Overflow has priority when both conditions occur together.
- FAULT_FATAL:
  - Sticky: tx_enable_o=1, tx_mode_o=TX_IDLE, tx_fault_fatal_o=1, local_rdy_flag_o=0.
  - Leaves only via reset or enable_i=0.
- Error code:
  - Written only on the edge that enters FAULT_FATAL; held afterwards.
  - A later error never overwrites it.
- fifo_overflow_i is ignored outside READY.

Decomposition:
- qeciphy_pkg additions:
  - qeciphy_tx_mode_t (TX_IDLE=2'd0, TX_TRAIN=2'd1, TX_DATA=2'd2).
  - qeciphy_error_t entries TX_TRAIN_TIMEOUT=4'h4, TX_FIFO_OVERFLOW=4'h5, TX_LINK_LOST=4'h6.
- Sub-module qeciphy_sat_counter:
  - Parameter MAX; ports clear and increment; output cnt sized by $clog2(MAX+1).
  - Saturates at MAX.
  - Instantiated twice, for train_cnt and tmo_cnt.

Test Plan:
Use MIN_TRAIN_CYCLES=16 and TIMEOUT_CYCLES=64 for all scenarios.
1. Reset release with enable_i=1, rx_rdy_i=1, remote_rx_rdy_i asserted at cycle 30 -> TRAINING at edge 2, local_rdy_flag_o=1 at edge 19, tx_rdy_o=1 and tx_mode_o=TX_DATA one cycle after remote_rx_rdy_i seen in WAIT_REMOTE.
2. rx_rdy_i held 0 -> tx_fault_fatal_o=1 and tx_error_code_o=4'h4 exactly 66 edges after reset release, tx_mode_o=TX_IDLE.
3. In READY, fifo_overflow_i and remote_rx_rdy_i=0 in the same cycle -> FAULT_FATAL next cycle with code 4'h5; a subsequent overflow pulse leaves code unchanged.
4. In WAIT_REMOTE, drop rx_rdy_i for 1 cycle -> return to TRAINING, local_rdy_flag_o=0, re-advance only after another 17 cycles of training.
5. enable_i=0 while in FAULT_FATAL -> next edge: all outputs zero, code NO_ERROR; re-enable -> TRAINING after 1 edge.
6. Assert rst_n_i low mid-READY between clock edges -> outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/qeciphy_pkg.sv
// Purpose: shared types for the qeciphy TX control path (TX mode, error codes, TX controller state).
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package qeciphy_pkg;

  // What the TX datapath transmits.
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_TRAIN = 2'd1,
    TX_DATA  = 2'd2
  } qeciphy_tx_mode_t;

  // Error codes reported upward; sticky once a fatal fault is taken.
  typedef enum logic [3:0] {
    NO_ERROR         = 4'h0,
    TX_TRAIN_TIMEOUT = 4'h4,
    TX_FIFO_OVERFLOW = 4'h5,
    TX_LINK_LOST     = 4'h6
  } qeciphy_error_t;

  // One-hot TX controller state.
  typedef enum logic [5:0] {
    ST_RESET       = 6'b000001,
    ST_OFF         = 6'b000010,
    ST_TRAINING    = 6'b000100,
    ST_WAIT_REMOTE = 6'b001000,
    ST_READY       = 6'b010000,
    ST_FAULT_FATAL = 6'b100000
  } qeciphy_tx_state_t;

endpackage

// File: rtl/qeciphy_tx_controller_sat_counter.sv
// Purpose: up-counter with synchronous clear that holds at MAX.
// Latency: count visible one cycle after an increment request.
// Backpressure: none; clear has priority over increment.
// Ports: clk_i/rst_n_i clock and async active-low reset, clear_i sync clear,
//        increment_i count enable, cnt_o current count.
module qeciphy_sat_counter #(
  parameter int MAX = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       clear_i,
  input  logic                       increment_i,
  output logic [$clog2(MAX+1)-1:0]   cnt_o
);

  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
    end else if (increment_i && (r_cnt != MAX_V)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/qeciphy_tx_controller.sv
// Purpose: sequences the TX path OFF -> TRAINING -> WAIT_REMOTE -> READY, and latches fatal faults.
// Latency: all outputs decoded from registered state/error code; one cycle from input to output change.
// Backpressure: none; enable_i=0 returns to OFF on the next edge from any state.
// Ports: clk_i/rst_n_i clock and async active-low reset; enable_i global enable; rx_rdy_i local RX locked;
//        remote_rx_rdy_i partner RX-ready flag; fifo_overflow_i TX FIFO overflow; tx_enable_o, tx_mode_o,
//        local_rdy_flag_o drive the TX datapath; tx_rdy_o, tx_fault_fatal_o, tx_error_code_o report upward.
module qeciphy_tx_controller
  import qeciphy_pkg::*;
#(
  parameter int MIN_TRAIN_CYCLES = 1024,
  parameter int TIMEOUT_CYCLES   = 1048576
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       enable_i,
  input  logic       rx_rdy_i,
  input  logic       remote_rx_rdy_i,
  input  logic       fifo_overflow_i,
  output logic       tx_enable_o,
  output logic [1:0] tx_mode_o,
  output logic       local_rdy_flag_o,
  output logic       tx_rdy_o,
  output logic       tx_fault_fatal_o,
  output logic [3:0] tx_error_code_o
);

  localparam int TW = $clog2(MIN_TRAIN_CYCLES + 1);
  localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TRAIN_DONE = TW'(MIN_TRAIN_CYCLES);
  localparam logic [OW-1:0] TMO_DONE   = OW'(TIMEOUT_CYCLES);

  qeciphy_tx_state_t r_state, w_next;
  qeciphy_error_t    r_err, w_err_next;

  logic [TW-1:0] w_train_cnt;
  logic [OW-1:0] w_tmo_cnt;
  logic          w_train_clr, w_train_inc;
  logic          w_tmo_clr, w_tmo_inc;
  logic          w_train_done, w_tmo_hit;

  assign w_train_done = (w_train_cnt == TRAIN_DONE);
  assign w_tmo_hit    = (w_tmo_cnt == TMO_DONE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_RESET;
      r_err   <= NO_ERROR;
    end else begin
      r_state <= w_next;
      r_err   <= w_err_next;
    end
  end

  // The error code only changes on a transition into FAULT_FATAL; FAULT_FATAL
  // itself never sets it, so a later error cannot overwrite the first one.
  always_comb begin
    w_next     = r_state;
    w_err_next = r_err;
    if (!enable_i) begin
      w_next     = ST_OFF;
      w_err_next = NO_ERROR;
    end else begin
      case (r_state)
        ST_RESET: w_next = ST_OFF;
        ST_OFF:   w_next = ST_TRAINING;
        ST_TRAINING: begin
          if (w_train_done && rx_rdy_i) begin
            w_next = ST_WAIT_REMOTE;
          end else if (w_tmo_hit) begin
            w_next     = ST_FAULT_FATAL;
            w_err_next = TX_TRAIN_TIMEOUT;
          end
        end
        ST_WAIT_REMOTE: begin
          if (remote_rx_rdy_i) begin
            w_next = ST_READY;
          end else if (w_tmo_hit) begin
            w_next     = ST_FAULT_FATAL;
            w_err_next = TX_TRAIN_TIMEOUT;
          end else if (!rx_rdy_i) begin
            w_next = ST_TRAINING;
          end
        end
        ST_READY: begin
          if (fifo_overflow_i) begin
            w_next     = ST_FAULT_FATAL;
            w_err_next = TX_FIFO_OVERFLOW;
          end else if (!remote_rx_rdy_i || !rx_rdy_i) begin
            w_next     = ST_FAULT_FATAL;
            w_err_next = TX_LINK_LOST;
          end
        end
        ST_FAULT_FATAL: w_next = ST_FAULT_FATAL;
        default:        w_next = ST_RESET;
      endcase
    end
  end

  // train_cnt counts completed TRAINING cycles of the current stint; it is
  // zeroed while in OFF and when WAIT_REMOTE falls back to TRAINING.
  assign w_train_clr = !enable_i || (r_state == ST_OFF) ||
                       ((r_state == ST_WAIT_REMOTE) && (w_next == ST_TRAINING));
  assign w_train_inc = (r_state == ST_TRAINING);

  // tmo_cnt is already zero in OFF (OFF is only reached through reset or
  // disable, both of which clear it). It counts on every edge that lands in
  // TRAINING/WAIT_REMOTE, so its value is the number of link-up cycles spent
  // including the current one; hitting TIMEOUT_CYCLES means the budget is used.
  assign w_tmo_clr = !enable_i;
  assign w_tmo_inc = (w_next == ST_TRAINING) || (w_next == ST_WAIT_REMOTE);

  qeciphy_sat_counter #(.MAX(MIN_TRAIN_CYCLES)) u_train_cnt (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .clear_i     (w_train_clr),
    .increment_i (w_train_inc),
    .cnt_o       (w_train_cnt)
  );

  qeciphy_sat_counter #(.MAX(TIMEOUT_CYCLES)) u_tmo_cnt (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .clear_i     (w_tmo_clr),
    .increment_i (w_tmo_inc),
    .cnt_o       (w_tmo_cnt)
  );

  assign tx_enable_o      = (r_state == ST_TRAINING) || (r_state == ST_WAIT_REMOTE) ||
                            (r_state == ST_READY)    || (r_state == ST_FAULT_FATAL);
  assign tx_mode_o        = ((r_state == ST_TRAINING) || (r_state == ST_WAIT_REMOTE)) ? TX_TRAIN :
                            (r_state == ST_READY) ? TX_DATA : TX_IDLE;
  assign local_rdy_flag_o = (r_state == ST_WAIT_REMOTE) || (r_state == ST_READY);
  assign tx_rdy_o         = (r_state == ST_READY);
  assign tx_fault_fatal_o = (r_state == ST_FAULT_FATAL);
  assign tx_error_code_o  = r_err;

endmodule

// File: tb/tb_qeciphy_tx_controller.sv
// Purpose: self-checking bench for qeciphy_tx_controller using a phase-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_qeciphy_tx_controller;
  import qeciphy_pkg::*;

  localparam int MIN_T = 16;
  localparam int TMO   = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, rx = 1'b0, rrx = 1'b0, ovf = 1'b0;
  logic       tx_en, lrdy, trdy, fat;
  logic [1:0] mode;
  logic [3:0] code;
  logic [9:0] act;

  int checks = 0;
  int errors = 0;

  qeciphy_tx_controller #(.MIN_TRAIN_CYCLES(MIN_T), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .enable_i         (en),
    .rx_rdy_i         (rx),
    .remote_rx_rdy_i  (rrx),
    .fifo_overflow_i  (ovf),
    .tx_enable_o      (tx_en),
    .tx_mode_o        (mode),
    .local_rdy_flag_o (lrdy),
    .tx_rdy_o         (trdy),
    .tx_fault_fatal_o (fat),
    .tx_error_code_o  (code)
  );

  always #5 clk = ~clk;

  assign act = {tx_en, mode, lrdy, trdy, fat, code};

  // Reference model: link phase, cycles spent in the current training stint,
  // and total cycles spent bringing the link up.
  typedef enum {M_RST, M_OFF, M_TRN, M_WAIT, M_RDY, M_FLT} mph_t;
  mph_t       ph;
  int         trn_t, link_t;
  logic [3:0] m_code;

  task automatic model_reset();
    ph = M_RST; trn_t = 0; link_t = 0; m_code = 4'h0;
  endtask

  task automatic model_fault(input logic [3:0] c);
    ph = M_FLT; m_code = c;
  endtask

  task automatic model_step();
    if (!en) begin
      ph = M_OFF; m_code = 4'h0; trn_t = 0; link_t = 0;
    end else begin
      case (ph)
        M_RST: ph = M_OFF;
        M_OFF: begin ph = M_TRN; trn_t = 0; link_t = 0; end
        M_TRN: begin
          trn_t++; link_t++;
          if (trn_t >= MIN_T + 1 && rx) ph = M_WAIT;
          else if (link_t >= TMO) model_fault(4'h4);
        end
        M_WAIT: begin
          link_t++;
          if (rrx) ph = M_RDY;
          else if (link_t >= TMO) model_fault(4'h4);
          else if (!rx) begin ph = M_TRN; trn_t = 0; end
        end
        M_RDY: begin
          if (ovf) model_fault(4'h5);
          else if (!rrx || !rx) model_fault(4'h6);
        end
        default: ;
      endcase
    end
  endtask

  // {tx_enable, mode, local_rdy, tx_rdy, fatal, code}
  function automatic logic [9:0] exp_vec();
    case (ph)
      M_TRN:   return {1'b1, 2'd1, 1'b0, 1'b0, 1'b0, m_code};
      M_WAIT:  return {1'b1, 2'd1, 1'b1, 1'b0, 1'b0, m_code};
      M_RDY:   return {1'b1, 2'd2, 1'b1, 1'b1, 1'b0, m_code};
      M_FLT:   return {1'b1, 2'd0, 1'b0, 1'b0, 1'b1, m_code};
      default: return {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, m_code};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #7;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    en = 1'b1; rx = 1'b1; rrx = 1'b1; ovf = 1'b1;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (act !== exp_vec()) begin
      errors++;
      $display("FAIL reset_values got=%b exp=%b", act, exp_vec());
    end
    ovf = 1'b0;
  endtask

  task automatic test_bringup();
    en = 1'b1; rx = 1'b1; rrx = 1'b0; ovf = 1'b0;
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      tick();
      checks++;
      if (act !== exp_vec()) begin
        errors++;
        $display("FAIL bringup_model edge=%0d got=%b exp=%b", e, act, exp_vec());
      end
      if (e == 2) begin
        checks++;
        if (mode !== TX_TRAIN || tx_en !== 1'b1) begin
          errors++;
          $display("FAIL bringup_training_edge2 mode=%0d en=%b exp mode=1 en=1", mode, tx_en);
        end
      end
      if (e == 18 || e == 19) begin
        checks++;
        if (lrdy !== (e == 19)) begin
          errors++;
          $display("FAIL bringup_local_rdy edge=%0d got=%b exp=%b", e, lrdy, (e == 19));
        end
      end
      if (e == 30 || e == 31) begin
        checks++;
        if (trdy !== (e == 31) || (e == 31 && mode !== TX_DATA)) begin
          errors++;
          $display("FAIL bringup_tx_rdy edge=%0d rdy=%b mode=%0d exp rdy=%b", e, trdy, mode, (e == 31));
        end
      end
      if (e == 30) rrx = 1'b1;
    end
  endtask

  task automatic test_timeout();
    en = 1'b1; rx = 1'b0; rrx = 1'b0; ovf = 1'b0;
    do_reset();
    for (int e = 1; e <= 70; e++) begin
      tick();
      checks++;
      if (act !== exp_vec()) begin
        errors++;
        $display("FAIL timeout_model edge=%0d got=%b exp=%b", e, act, exp_vec());
      end
      if (e == 65) begin
        checks++;
        if (fat !== 1'b0) begin
          errors++;
          $display("FAIL timeout_early edge=65 fatal=%b exp=0", fat);
        end
      end
      if (e == 66) begin
        checks++;
        if (fat !== 1'b1 || code !== 4'h4 || mode !== TX_IDLE) begin
          errors++;
          $display("FAIL timeout_fault edge=66 fatal=%b code=%h mode=%0d exp 1/4/0", fat, code, mode);
        end
      end
    end
  endtask

  task automatic test_overflow();
    en = 1'b1; rx = 1'b1; rrx = 1'b1; ovf = 1'b0;
    do_reset();
    repeat (22) tick();
    checks++;
    if (trdy !== 1'b1 || act !== exp_vec()) begin
      errors++;
      $display("FAIL overflow_ready got=%b exp=%b", act, exp_vec());
    end
    ovf = 1'b1; rrx = 1'b0;
    tick();
    checks++;
    if (fat !== 1'b1 || code !== 4'h5 || act !== exp_vec()) begin
      errors++;
      $display("FAIL overflow_priority fatal=%b code=%h exp 1/5", fat, code);
    end
    ovf = 1'b0; tick();
    ovf = 1'b1; tick();
    ovf = 1'b0; rrx = 1'b1; tick();
    checks++;
    if (code !== 4'h5 || fat !== 1'b1 || act !== exp_vec()) begin
      errors++;
      $display("FAIL overflow_sticky fatal=%b code=%h exp 1/5", fat, code);
    end
  endtask

  task automatic test_rx_drop();
    en = 1'b1; rrx = 1'b0; ovf = 1'b0; rx = 1'b1;
    do_reset();
    for (int e = 1; e <= 45; e++) begin
      rx = (e != 21);
      tick();
      checks++;
      if (act !== exp_vec()) begin
        errors++;
        $display("FAIL rxdrop_model edge=%0d got=%b exp=%b", e, act, exp_vec());
      end
      if (e == 21 || e == 37 || e == 38) begin
        checks++;
        if (lrdy !== (e == 38) || mode !== TX_TRAIN) begin
          errors++;
          $display("FAIL rxdrop_retrain edge=%0d lrdy=%b mode=%0d exp lrdy=%b mode=1", e, lrdy, mode, (e == 38));
        end
      end
    end
  endtask

  task automatic test_disable();
    en = 1'b1; rx = 1'b0; rrx = 1'b0; ovf = 1'b0;
    do_reset();
    repeat (68) tick();
    checks++;
    if (fat !== 1'b1 || act !== exp_vec()) begin
      errors++;
      $display("FAIL disable_prefault got=%b exp=%b", act, exp_vec());
    end
    en = 1'b0;
    tick();
    checks++;
    if (act !== 10'd0 || act !== exp_vec()) begin
      errors++;
      $display("FAIL disable_clear got=%b exp=%b", act, exp_vec());
    end
    en = 1'b1;
    tick();
    checks++;
    if (mode !== TX_TRAIN || tx_en !== 1'b1 || code !== 4'h0 || act !== exp_vec()) begin
      errors++;
      $display("FAIL disable_reenable got=%b exp=%b", act, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    en = 1'b1; rx = 1'b1; rrx = 1'b1; ovf = 1'b0;
    do_reset();
    repeat (24) tick();
    checks++;
    if (trdy !== 1'b1) begin
      errors++;
      $display("FAIL async_pre_ready tx_rdy=%b exp=1", trdy);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (act !== exp_vec()) begin
      errors++;
      $display("FAIL async_reset got=%b exp=%b", act, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int run = 0; run < 6; run++) begin
      en = 1'b1; rx = 1'b1; rrx = 1'b0; ovf = 1'b0;
      do_reset();
      for (int c = 0; c < 400; c++) begin
        en  = ($urandom_range(0, 149) != 0);
        rx  = (run < 3) ? ($urandom_range(0, 31) != 0) : ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, (run % 2 == 0) ? 19 : 79) == 0) rrx = ~rrx;
        ovf = ($urandom_range(0, 99) == 0);
        tick();
        checks++;
        if (act !== exp_vec()) begin
          errors++;
          $display("FAIL random_model run=%0d cycle=%0d got=%b exp=%b", run, c, act, exp_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_timeout();
    test_overflow();
    test_rx_drop();
    test_disable();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
